// File: rtl/bool_lut_pipe_if.sv
// Handshake bundle for bool_lut_pipe: table configuration, input/output beats and hit counter.
// The master side drives requests and beats; the slave side is the function unit.
interface bool_lut_pipe_if #(
    parameter int N_IN  = 3,
    parameter int CH    = 4,
    parameter int CNT_W = 16
);
    logic                   cfg_we;
    logic [(2**N_IN)-1:0]   cfg_data;
    logic                   cfg_ack;
    logic                   in_valid;
    logic                   in_ready;
    logic [CH*N_IN-1:0]     in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [CH-1:0]          out_data;
    logic                   cnt_clr;
    logic [CNT_W-1:0]       hit_cnt;

    modport master (
        output cfg_we, cfg_data, in_valid, in_data, out_ready, cnt_clr,
        input  cfg_ack, in_ready, out_valid, out_data, hit_cnt
    );

    modport slave (
        input  cfg_we, cfg_data, in_valid, in_data, out_ready, cnt_clr,
        output cfg_ack, in_ready, out_valid, out_data, hit_cnt
    );
endinterface

// File: rtl/bool_lut_pipe.sv
// Multi-channel truth-table function unit: two-stage valid/ready pipeline sharing one
// programmable table, plus a saturating count of true results leaving the block.
module bool_lut_pipe #(
    parameter int                   N_IN     = 3,
    parameter int                   CH       = 4,
    parameter logic [(2**N_IN)-1:0] TT_RESET = 8'h15,
    parameter int                   CNT_W    = 16
) (
    input logic              clk,
    input logic              rst,
    bool_lut_pipe_if.slave   lut_if
);
    localparam int TT_W  = 2**N_IN;
    localparam int PC_W  = $clog2(CH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        CFG_IDLE,
        CFG_ACK
    } cfg_state_e;

    cfg_state_e          cfg_state_q, cfg_state_d;
    logic [TT_W-1:0]     tt_q, tt_d;
    logic [CH*N_IN-1:0]  s1_data_q, s1_data_d;
    logic                v1_q, v1_d;
    logic [CH-1:0]       out_q, out_d;
    logic                v2_q, v2_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                s2_load;
    logic                s1_free;
    logic                s1_take;
    logic                transfer;
    logic                cfg_write;
    logic [PC_W-1:0]     hits;
    logic [SUM_W-1:0]    sum;

    assign s2_load   = v1_q & (~v2_q | lut_if.out_ready);
    assign s1_free   = ~v1_q | s2_load;
    assign s1_take   = lut_if.in_valid & lut_if.in_ready;
    assign transfer  = v2_q & lut_if.out_ready;
    // The table only changes with the pipeline empty, so no beat ever sees a mixed table.
    assign cfg_write = (cfg_state_q == CFG_IDLE) & lut_if.cfg_we & ~v1_q & ~v2_q;

    assign lut_if.in_ready  = s1_free & ~lut_if.cfg_we;
    assign lut_if.out_valid = v2_q;
    assign lut_if.out_data  = out_q;
    assign lut_if.hit_cnt   = cnt_q;
    assign lut_if.cfg_ack   = (cfg_state_q == CFG_ACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_state_q <= CFG_IDLE;
        end else begin
            cfg_state_q <= cfg_state_d;
        end
    end

    // The ACK state blocks a second write while the requester is still seeing the pulse.
    always_comb begin
        cfg_state_d = cfg_state_q;
        case (cfg_state_q)
            CFG_IDLE: if (cfg_write) cfg_state_d = CFG_ACK;
            CFG_ACK:  cfg_state_d = CFG_IDLE;
            default:  cfg_state_d = CFG_IDLE;
        endcase
    end

    always_comb begin
        hits = '0;
        for (int i = 0; i < CH; i++) begin
            hits = hits + PC_W'(out_q[i]);
        end
        sum = SUM_W'(cnt_q) + SUM_W'(hits);
    end

    always_comb begin
        tt_d      = tt_q;
        s1_data_d = s1_data_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        v1_d      = s1_take | (v1_q & ~s2_load);
        v2_d      = s2_load | (v2_q & ~lut_if.out_ready);

        if (s1_take) begin
            s1_data_d = lut_if.in_data;
        end
        if (s2_load) begin
            for (int i = 0; i < CH; i++) begin
                out_d[i] = tt_q[s1_data_q[i*N_IN +: N_IN]];
            end
        end
        if (cfg_write) begin
            tt_d = lut_if.cfg_data;
        end
        // Clear takes priority over a coincident transfer.
        if (lut_if.cnt_clr) begin
            cnt_d = '0;
        end else if (transfer) begin
            cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q      <= TT_RESET;
            s1_data_q <= '0;
            v1_q      <= 1'b0;
            out_q     <= '0;
            v2_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            tt_q      <= tt_d;
            s1_data_q <= s1_data_d;
            v1_q      <= v1_d;
            out_q     <= out_d;
            v2_q      <= v2_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_bool_lut_pipe.sv
// Scoreboard bench for bool_lut_pipe: stimulus pushes hand-computed results, a negedge
// monitor pops them as beats leave and tracks the expected saturating hit count.
module tb_bool_lut_pipe;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   expCnt = 0;
    logic [3:0] sbQueue[$];

    // Default table 8'h15 is true only for indices 0, 2 and 4.
    logic [11:0] streamIn [8] = '{12'b000_010_100_110, 12'b111_101_011_001,
                                  12'b100_100_100_100, 12'b001_000_011_010,
                                  12'b110_111_000_101, 12'b010_011_100_000,
                                  12'b101_100_010_111, 12'b000_001_010_011};
    logic [3:0]  streamExp[8] = '{4'b1110, 4'b0000, 4'b1111, 4'b0101,
                                  4'b0010, 4'b1011, 4'b0110, 4'b1010};

    bool_lut_pipe_if #(.N_IN(3), .CH(4), .CNT_W(4)) bus ();

    bool_lut_pipe #(.N_IN(3), .CH(4), .TT_RESET(8'h15), .CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .lut_if (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting, expected DUT event", name);
    endtask

    // Call aligned to posedge+1; returns aligned the same way with in_valid low.
    task automatic applyStimulus(input logic [11:0] data, input logic [3:0] exp);
        int n = 0;
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) reportTimeout("accept");
        else sbQueue.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        @(negedge clk);
        while ((sbQueue.size() != 0 || bus.out_valid) && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (n >= 60) reportTimeout("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input logic [7:0] data);
        int n = 0;
        bus.cfg_data = data;
        bus.cfg_we   = 1'b1;
        @(negedge clk);
        while (!bus.cfg_ack && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!bus.cfg_ack) begin
            reportTimeout("cfg_ack");
        end else begin
            checkOutput("cfg_ack_pending_beats", sbQueue.size(), 0);
            checkOutput("cfg_ack_out_valid", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        @(negedge clk);
        checkOutput("cfg_ack_pulse", bus.cfg_ack, 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor compares first, then advances the model across the coming edge.
    always @(negedge clk) begin
        logic [3:0] popped;
        checkOutput("hit_cnt", bus.hit_cnt, expCnt);
        if (bus.out_valid) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got out_data %0h, expected no beat", bus.out_data);
            end else begin
                checkOutput("out_data", bus.out_data, sbQueue[0]);
            end
        end
        if (rst) begin
            sbQueue.delete();
            expCnt = 0;
        end else begin
            if (bus.out_valid && bus.out_ready && sbQueue.size() != 0) begin
                popped = sbQueue.pop_front();
                if (!bus.cnt_clr) begin
                    expCnt = expCnt + $countones(popped);
                    if (expCnt > CNT_MAX) expCnt = CNT_MAX;
                end
            end
            if (bus.cnt_clr) expCnt = 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_data  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus.cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_out_data", bus.out_data, 0);
        checkOutput("reset_hit_cnt", bus.hit_cnt, 0);
        checkOutput("reset_cfg_ack", bus.cfg_ack, 0);
        checkOutput("reset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        $display("[TB] test 1: default table, single beat");
        applyStimulus(12'b000_001_110_100, 4'b1001);
        @(negedge clk);
        checkOutput("latency_not_early", bus.out_valid, 0);
        @(negedge clk);
        checkOutput("latency_valid", bus.out_valid, 1);
        @(negedge clk);
        checkOutput("hit_cnt_first", bus.hit_cnt, 2);
        @(posedge clk);
        #1;

        $display("[TB] test 2: streaming with backpressure");
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(streamIn[i], streamExp[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                checkOutput("in_ready_both_full", bus.in_ready, 0);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] test 3: reprogramming with beats in flight");
        applyStimulus(12'b100_100_100_100, 4'b1111);
        applyStimulus(12'b111_101_011_001, 4'b0000);
        cfgWrite(8'hFF);
        applyStimulus(12'b000_000_000_000, 4'b1111);
        waitDrain();

        $display("[TB] test 4: saturation and clear");
        bus.cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(12'h000, 4'b1111);
        waitDrain();
        checkOutput("hit_cnt_saturated", bus.hit_cnt, 15);
        bus.out_ready = 1'b0;
        applyStimulus(12'h000, 4'b1111);
        begin
            int n = 0;
            @(negedge clk);
            while (!bus.out_valid && n < 60) begin
                n++;
                @(negedge clk);
            end
            if (!bus.out_valid) reportTimeout("stalled_beat");
        end
        @(posedge clk);
        #1;
        bus.cnt_clr   = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cnt_clr = 1'b0;
        @(negedge clk);
        checkOutput("clear_beats_transfer", bus.hit_cnt, 0);
        @(posedge clk);
        #1;

        $display("[TB] test 5: reset mid-stream");
        applyStimulus(12'h000, 4'b1111);
        waitDrain();
        checkOutput("hit_cnt_before_reset", bus.hit_cnt, 4);
        cfgWrite(8'h00);
        bus.out_ready = 1'b0;
        applyStimulus(12'b000_010_100_110, 4'b0000);
        applyStimulus(12'b100_100_100_100, 4'b0000);
        @(negedge clk);
        checkOutput("full_before_reset_in_ready", bus.in_ready, 0);
        checkOutput("full_before_reset_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        bus.cfg_data = 8'hAA;
        bus.cfg_we   = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_out_valid", bus.out_valid, 0);
        checkOutput("post_reset_hit_cnt", bus.hit_cnt, 0);
        checkOutput("post_reset_cfg_ack", bus.cfg_ack, 0);
        @(posedge clk);
        #1;
        applyStimulus(12'b000_010_100_110, 4'b1110);
        checkOutput("post_reset_cfg_ack_later", bus.cfg_ack, 0);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
